// File: rtl/onewire_sampler.sv
// onewire_sampler: multi-channel 1-wire capture engine.
//
// Samples CHN open-drain 1-wire lines every cfg_div+1 clocks, packs PK = 8/CHN
// samples per byte (first sample in the LSBs) and queues the bytes in an FD-deep
// FIFO. The FIFO drains over a valid/ready byte stream as a raw sigrok .bin dump.
//
// Optional build macro: ONEWIRE_SAMPLER_LEN_EN adds cfg_len, which sets a capture
// length in strobes (0 = unlimited).
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   owr      in   CHN line levels, asynchronous to clk
//   cfg_div  in   sample period minus 1, latched at start
//   cfg_trg  in   0 = capture at once, 1 = arm and wait for any falling edge
//   cfg_len  in   (ONEWIRE_SAMPLER_LEN_EN only) strobes per capture, 0 = unlimited
//   run      in   level request: high = capture, low = stop
//   busy     out  engine not idle
//   ovf      out  sticky: a byte was dropped on a full FIFO
//   m_valid  out  output byte available
//   m_ready  in   sink accepts the byte
//   m_data   out  output byte (FIFO head)
module onewire_sampler #(
  parameter int unsigned CHN = 4,
  parameter int unsigned DW  = 16,
  parameter int unsigned FD  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [CHN-1:0] owr,
  input  logic [DW-1:0]  cfg_div,
  input  logic           cfg_trg,
`ifdef ONEWIRE_SAMPLER_LEN_EN
  input  logic [DW-1:0]  cfg_len,
`endif
  input  logic           run,
  output logic           busy,
  output logic           ovf,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [7:0]     m_data
);

  localparam int unsigned PK = 8 / CHN;
  localparam int unsigned SW = (PK > 1) ? $clog2(PK) : 1;
  localparam int unsigned AW = $clog2(FD);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StArm     = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StFlush   = 2'd3;

  // Synchronizer and edge-detect history; idle lines are pulled up, hence all 1s.
  logic [CHN-1:0] sync1_q, sync2_q, prev_q;
  logic           fall;

  logic [1:0]     state_q, state_d;
  logic [DW-1:0]  div_lat_q, div_lat_d;
  logic [DW-1:0]  div_q, div_d;
  logic [SW-1:0]  slot_q, slot_d;
  logic [7:0]     pack_q, pack_d;
  logic [CHN-1:0] last_q, last_d;
  logic           ovf_q, ovf_d;

  logic           start, strobe, len_done;
  logic           push;
  logic [7:0]     push_byte;

  logic [7:0]     mem_q [FD];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           full, pop, wr_en, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= owr;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall = |(prev_q & ~sync2_q);

`ifdef ONEWIRE_SAMPLER_LEN_EN
  // hold_q blocks a restart after an automatic stop until run has been seen low.
  logic [DW-1:0] len_q, len_d;
  logic [DW-1:0] scnt_q, scnt_d;
  logic          hold_q, hold_d;

  assign start    = (state_q == StIdle) && run && !hold_q;
  assign len_done = strobe && (len_q != '0) && (scnt_q == len_q - DW'(1));

  always_comb begin
    len_d  = len_q;
    scnt_d = scnt_q;
    hold_d = hold_q;
    if (start) begin
      len_d  = cfg_len;
      scnt_d = '0;
    end else if (strobe) begin
      scnt_d = scnt_q + DW'(1);
    end
    if (len_done) begin
      hold_d = 1'b1;
    end else if ((state_q == StIdle) && !run) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      scnt_q <= '0;
      hold_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      scnt_q <= scnt_d;
      hold_q <= hold_d;
    end
  end
`else
  assign start    = (state_q == StIdle) && run;
  assign len_done = 1'b0;
`endif

  // A stop request wins over the strobe in the same cycle.
  assign strobe = (state_q == StCapture) && run && (div_q == '0);

  always_comb begin
    state_d   = state_q;
    div_lat_d = div_lat_q;
    div_d     = div_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_lat_d = cfg_div;
          div_d     = '0;
          state_d   = cfg_trg ? StArm : StCapture;
        end
      end
      StArm: begin
        div_d = '0;
        if (!run) begin
          state_d = StIdle;
        end else if (fall) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        div_d = (div_q == div_lat_q) ? '0 : div_q + DW'(1);
        if (!run || len_done) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Packing: a strobe writes its slot and pushes when the byte is complete;
  // FLUSH pads the unwritten slots with the last sample.
  always_comb begin
    push      = 1'b0;
    push_byte = pack_q;
    pack_d    = pack_q;
    slot_d    = slot_q;
    last_d    = last_q;
    if (start) begin
      slot_d = '0;
      pack_d = '0;
    end
    if (strobe) begin
      for (int k = 0; k < PK; k++) begin
        if (SW'(k) == slot_q) push_byte[CHN*k +: CHN] = sync2_q;
      end
      pack_d = push_byte;
      last_d = sync2_q;
      if (slot_q == SW'(PK - 1)) begin
        push   = 1'b1;
        slot_d = '0;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
    if ((state_q == StFlush) && (slot_q != '0)) begin
      for (int k = 0; k < PK; k++) begin
        if (SW'(k) >= slot_q) push_byte[CHN*k +: CHN] = last_q;
      end
      push   = 1'b1;
      slot_d = '0;
    end
  end

  assign full    = (cnt_q == (AW + 1)'(FD));
  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign m_data  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (start) begin
      ovf_d = 1'b0;
    end else if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_lat_q <= '0;
      div_q     <= '0;
      slot_q    <= '0;
      pack_q    <= '0;
      last_q    <= '1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FD; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      div_lat_q <= div_lat_d;
      div_q     <= div_d;
      slot_q    <= slot_d;
      pack_q    <= pack_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= push_byte;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_onewire_sampler.sv
// tb_onewire_sampler: directed and randomized bench for onewire_sampler (CHN=4,
// FD=16). Expected bytes come from the list of sample values each run is meant to
// capture: ceil(capture_cycles / period) samples, packed LSB-first and padded
// with the last sample.
module tb_onewire_sampler;

  localparam int unsigned CHN = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned FD  = 16;
  localparam int unsigned PK  = 8 / CHN;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [CHN-1:0] owr;
  logic [DW-1:0]  cfg_div;
  logic           cfg_trg;
`ifdef ONEWIRE_SAMPLER_LEN_EN
  logic [DW-1:0]  cfg_len;
`endif
  logic           run;
  logic           busy, ovf, m_valid, m_ready;
  logic [7:0]     m_data;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  onewire_sampler #(.CHN(CHN), .DW(DW), .FD(FD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .owr     (owr),
    .cfg_div (cfg_div),
    .cfg_trg (cfg_trg),
`ifdef ONEWIRE_SAMPLER_LEN_EN
    .cfg_len (cfg_len),
`endif
    .run     (run),
    .busy    (busy),
    .ovf     (ovf),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge; a handshake seen here completes on the next posedge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // One capture: run held for ncap CAPTURE cycles, new line value after each
  // strobe (when the period allows the synchronizer to settle). fixval < 0
  // picks random values.
  task automatic cap_run(input int div, input int ncap, input logic rdy, input int fixval);
    int p, n, idx;
    logic [CHN-1:0] vals[$];
    logic [7:0] b;
    p = div + 1;
    n = (ncap + p - 1) / p;
    for (int j = 0; j < n; j++) begin
      if (fixval >= 0) vals.push_back(CHN'(fixval));
      else if (p < 3 && j > 0) vals.push_back(vals[0]);
      else vals.push_back(CHN'($urandom));
    end
    cfg_div = DW'(div);
    cfg_trg = 1'b0;
    m_ready = rdy;
    owr     = vals[0];
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    check("ovf_clear_on_start", ovf, 0);
    check("busy_capture", busy, 1);
    for (int c = 0; c < ncap; c++) begin
      if (p >= 3 && c % p == 1 && c / p + 1 < n) owr = vals[c / p + 1];
      @(negedge clk);
    end
    run = 1'b0;
    @(negedge clk);
    check("busy_flush", busy, 1);
    @(negedge clk);
    check("busy_idle", busy, 0);
    for (int s = 0; s < n; s += PK) begin
      b = '0;
      for (int k = 0; k < PK; k++) begin
        idx = (s + k < n) ? s + k : n - 1;
        b[CHN*k +: CHN] = vals[idx];
      end
      if (rdy || exp_q.size() < FD) exp_q.push_back(b);
    end
    if (rdy) repeat (FD + 4) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    owr     = '1;
    cfg_div = '0;
    cfg_trg = 1'b0;
    run     = 1'b0;
    m_ready = 1'b0;
`ifdef ONEWIRE_SAMPLER_LEN_EN
    cfg_len = '0;
`endif
    #1;
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Every-clock sampling: 4 samples of A -> AA, AA, nothing from FLUSH.
    cap_run(0, 4, 1'b1, 4'hA);
    cmp_bytes("div0_aa");

    // Period 10: 35 cycles -> 4 samples; 45 cycles -> 5 samples, last byte padded.
    cap_run(9, 35, 1'b1, 4'h5);
    cmp_bytes("div9_35");
    cap_run(9, 45, 1'b1, 4'h5);
    cmp_bytes("div9_45_pad");

    // Randomized periods, lengths and line values.
    for (int it = 0; it < 8; it++) begin
      cap_run($urandom_range(2, 9), $urandom_range(1, 50), 1'b1, -1);
      cmp_bytes("rand");
    end

    // Trigger: nothing while armed, then the first capture sample is B.
    cfg_trg = 1'b1;
    cfg_div = DW'(3);
    owr     = '1;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b1;
    repeat (100) @(negedge clk);
    check("arm_no_bytes", got_q.size(), 0);
    check("arm_busy", busy, 1);
    owr = 4'hB;
    repeat (19) @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("trg_idle", busy, 0);
    repeat (20) @(negedge clk);
    exp_q.push_back(8'hBB);
    exp_q.push_back(8'hBB);
    cmp_bytes("trg_bb");

    // Arm abort: run drops before any edge.
    owr = '1;
    repeat (4) @(negedge clk);
    run = 1'b1;
    repeat (10) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check("arm_abort_idle", busy, 0);
    repeat (5) @(negedge clk);
    cmp_bytes("arm_abort");

    // Overflow: 20 bytes into a 16-deep FIFO with the sink stalled.
    cap_run(2, 120, 1'b0, -1);
    check("ovf_set", ovf, 1);
    check("ovf_valid", m_valid, 1);
    for (int s = 0; s < 4; s++) begin
      check("stall_data", m_data, exp_q[0]);
      @(negedge clk);
    end
    m_ready = 1'b1;
    repeat (FD + 4) @(negedge clk);
    cmp_bytes("ovf_drain");
    check("ovf_sticky_idle", ovf, 1);
    check("drained_valid", m_valid, 0);

    // Reset mid-capture with 5 bytes queued.
    m_ready = 1'b0;
    cfg_div = '0;
    cfg_trg = 1'b0;
    owr     = 4'h6;
    repeat (4) @(negedge clk);
    run = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_data", m_data, 0);
    @(negedge clk);
    run   = 1'b0;
    rst_n = 1'b1;
    got_q.delete();
    cap_run(4, 20, 1'b1, -1);
    cmp_bytes("post_rst");

`ifdef ONEWIRE_SAMPLER_LEN_EN
    // Length limit: 3 strobes -> 33, 33 (padded), no restart while run stays high.
    cfg_len = DW'(3);
    cfg_div = '0;
    cfg_trg = 1'b0;
    owr     = 4'h3;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b1;
    repeat (30) @(negedge clk);
    check("len_idle", busy, 0);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h33);
    cmp_bytes("len3");
    run = 1'b0;
    repeat (2) @(negedge clk);
    cfg_len = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onewire_sampler.md
Name: onewire_sampler

Overview:
- Synthesizable multi-channel 1-wire bus capture engine.
- Samples CHN open-drain 1-wire lines at a programmable period and packs samples into bytes.
- Buffers the bytes in a FIFO and streams them out over a valid/ready byte interface, in the raw .bin dump format produced for sigrok.
- Sits between the pad-level `owr` lines and a host/UART/USB byte transport. Generalizes the fixed single-channel, fixed-period simulation sampler to N channels, runtime period, trigger and back-pressure.

Parameters:
- CHN, 4, number of sampled 1-wire lines; legal values 1, 2, 4, 8.
- DW, 16, width of the sample-period divider.
- FD, 16, FIFO depth in bytes; power of 2, at least 2.
- PK, 8/CHN (derived localparam), samples packed per output byte.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- owr  input  CHN  1-wire line levels, asynchronous to clk.
- cfg_div  input  DW  sample period minus 1, in clk cycles.
- cfg_trg  input  1  0 = start immediately; 1 = wait for a falling edge on any channel.
- run  input  1  level; high requests capture, low requests stop.
- busy  output  1  high when state is not IDLE.
- ovf  output  1  sticky overflow flag (a byte was dropped).
- m_valid  output  1  output byte available.
- m_ready  input  1  sink accepts the byte.
- m_data  output  8  output byte.

Behaviour:
- Reset is asynchronous, active-low. Every flop clears immediately, including when asserted mid-capture:
  - busy=0, ovf=0, m_valid=0, m_data=0;
  - FIFO empty;
  - synchronizer flops = all 1s (pulled-up idle);
  - divider=0, pack slot=0.
- Input path: 2-flop synchronizer per channel. The previous synced value is kept for edge detection. Falling edge = prev 1, current 0.
- States:
  - IDLE: run=1 → latch cfg_div and cfg_trg, clear ovf, clear pack slot. Go to CAPTURE if cfg_trg=0, else ARM.
  - ARM: falling edge on any channel → CAPTURE. run=0 → IDLE, nothing emitted.
  - CAPTURE: divider cleared to 0 on entry. Sample strobe when divider==0. Divider counts 0..cfg_div_latched and wraps. First sample is taken in the first CAPTURE cycle, then every cfg_div+1 cycles; cfg_div=0 gives a sample every clk. run=0 → FLUSH; no strobe in that cycle.
  - FLUSH, one cycle: if pack slot != 0, fill the remaining slots with the last sample and push the byte. Then → IDLE.
- Packing: the sample for slot k goes to bits [CHN*k +: CHN]; the first sample is in the LSBs. When slot PK-1 is written, the byte is pushed that same cycle and the slot wraps to 0.
- Latency: from the strobe that completes a byte, the push lands and m_valid rises on the next clk when the FIFO was empty. Synchronizer delay is 2 clk, input to sample.
- FIFO:
  - m_valid = not empty; m_data = head.
  - Pop on m_valid & m_ready.
  - m_valid never depends on m_ready; m_data is held stable while m_valid & !m_ready.
- Full FIFO:
  - push without pop in the same cycle → byte dropped, ovf=1, occupancy unchanged;
  - push with simultaneous pop → accepted, occupancy unchanged.
- Empty FIFO: pop is not possible.
- Pointers wrap modulo FD. Occupancy counter is log2(FD)+1 bits.
- cfg_div and cfg_trg changes outside IDLE are ignored until the next start.
- ovf stays set through IDLE and clears only on the next start or reset.
- The FIFO keeps draining in IDLE.

Optional Feature:
- Macro: ONEWIRE_SAMPLER_LEN_EN.
- Defined: adds input `cfg_len`, DW bits, latched at start; 0 = unlimited. CAPTURE ends automatically after cfg_len strobes, even while run=1, entering FLUSH the next cycle. After that stop, the block returns to IDLE and waits for run to go low, then high again, before restarting.
- Not defined: the port is absent and capture stops only on run=0.

Test Plan:
- CHN=4, cfg_div=0, cfg_trg=0, owr held 4'hA, run high for 4 clk, m_ready=1 → two bytes 8'hAA, then FLUSH emits nothing; busy low 1 clk after FLUSH.
- CHN=4, cfg_div=9, owr=4'h5, run for 35 clk → strobes at 0,10,20,30 (4 samples, 2 bytes 8'h55, no pad). Then stop after 45 clk → 5 samples, third byte 8'h55 via pad.
- cfg_trg=1, owr idle 4'hF for 100 clk, then bit2 falls → no bytes during ARM; first sample 4'hB is taken in the first CAPTURE cycle.
- m_ready=0, cfg_div=0, FD=16, CHN=8, run for 20 clk → exactly 16 bytes retained, ovf=1. Then m_ready=1 → 16 bytes drained in order; m_data stable while stalled.
- Assert rst_n low mid-CAPTURE with 5 bytes queued → m_valid=0, busy=0, ovf=0 immediately; after release, the next run produces clean bytes.
- With ONEWIRE_SAMPLER_LEN_EN, cfg_len=3, CHN=4, owr=4'h3, run held high → exactly 2 bytes, 8'h33 and 8'h33 (padded), then IDLE with no restart until run toggles.
